controle_reabastecimento: RTL and testbench

Sequencer for cork-tray replenishment in the sealing line. It tracks corks in the tray, requests one batch from the cork dispenser when the tray falls to the low threshold, and tracks the dispenser stock in batches. A req/ack handshake with a timeout drives the dispenser mechanism. It also produces the line-stop and alarm signals.

---
 rtl/controle_reabastecimento_if.sv | 39 +++
 rtl/controle_reabastecimento.sv | 113 +++++++++++
 tb/tb_controle_reabastecimento.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/controle_reabastecimento_if.sv
// controle_reabastecimento_if
// Bundle of the cork-tray sequencer signals, excluding clk and rst.
//   master : the sequencer. It receives the cork/stock/ack events and drives
//            disp_req plus the tray and stock status outputs.
//   slave  : the sealing line and dispenser side (the mirror of master).
// Optional macro CONTADOR_LOTES_EN adds total_lotes, an 8-bit delivered-batch count.
interface controle_reabastecimento_if #(
  parameter int TRAY_W  = 5,
  parameter int STOCK_W = 3
);
  logic               rolha_usada;
  logic               abastecer_estoque;
  logic               disp_ack;
  logic               disp_req;
  logic [TRAY_W-1:0]  qt_bandeja;
  logic [STOCK_W-1:0] qt_estoque;
  logic               bloquear;
  logic               estoque_vazio;
  logic               falha;
`ifdef CONTADOR_LOTES_EN
  logic [7:0]         total_lotes;
`endif

  modport master (
    input  rolha_usada, abastecer_estoque, disp_ack,
`ifdef CONTADOR_LOTES_EN
    output total_lotes,
`endif
    output disp_req, qt_bandeja, qt_estoque, bloquear, estoque_vazio, falha
  );

  modport slave (
    output rolha_usada, abastecer_estoque, disp_ack,
`ifdef CONTADOR_LOTES_EN
    input  total_lotes,
`endif
    input  disp_req, qt_bandeja, qt_estoque, bloquear, estoque_vazio, falha
  );
endinterface

// File: rtl/controle_reabastecimento.sv
// controle_reabastecimento
// Cork-tray replenishment sequencer for the sealing line. It counts the corks
// in the tray and asks the dispenser for one batch once the tray is low. It
// counts the dispenser stock in batches, runs the req/ack handshake with a
// timeout, and flags line stop, empty stock and a sticky dispenser fault.
// Ports:
//   clk  : system clock, rising edge
//   rst  : synchronous reset, active high
//   bus  : controle_reabastecimento_if.master
//          in : rolha_usada, abastecer_estoque, disp_ack
//          out: disp_req, qt_bandeja, qt_estoque, bloquear, estoque_vazio, falha
//          (and total_lotes when CONTADOR_LOTES_EN is defined)
// Optional macro CONTADOR_LOTES_EN adds a saturating 8-bit delivered-batch counter.
//
// state    | meaning
// IDLE     | watching the tray level; request once low and stock remains
// SOLICITA | disp_req high, waiting for ack with timeout
// CARREGA  | one cycle: batch lands in tray, stock decrements
// FALHA    | dispenser timed out; sticky until rst
module controle_reabastecimento #(
  parameter int BATCH         = 20,
  parameter int LOW_THRESH    = 5,
  parameter int STOCK_BATCHES = 5,
  parameter int TRAY_MAX      = 25,
  parameter int TIMEOUT       = 15
) (
  input logic clk,
  input logic rst,
  controle_reabastecimento_if.master bus
);
  localparam int TRAY_W  = $clog2(TRAY_MAX + 1);
  localparam int STOCK_W = $clog2(STOCK_BATCHES + 1);
  localparam int TO_W    = $clog2(TIMEOUT + 1);
  localparam int TW1     = TRAY_W + 1;

  typedef enum logic [1:0] {IDLE, SOLICITA, CARREGA, FALHA} state_t;

  state_t             state, state_nxt;
  logic [TO_W-1:0]    to_cnt, to_cnt_nxt;
  logic [TRAY_W-1:0]  tray;
  logic [STOCK_W-1:0] stock;
  logic [TW1-1:0]     tray_sum;
  logic [TRAY_W-1:0]  tray_sat;
`ifdef CONTADOR_LOTES_EN
  logic [7:0]         lotes;
`endif

  // One extra bit so that tray + BATCH can go past TRAY_MAX before it is clamped.
  always_comb begin
    tray_sum = {1'b0, tray} + TW1'(BATCH) - TW1'(bus.rolha_usada);
    tray_sat = (tray_sum > TW1'(TRAY_MAX)) ? TRAY_W'(TRAY_MAX) : tray_sum[TRAY_W-1:0];
  end

  always_comb begin
    state_nxt  = state;
    to_cnt_nxt = to_cnt;
    case (state)
      IDLE: begin
        to_cnt_nxt = '0;
        if (tray <= TRAY_W'(LOW_THRESH) && stock != '0) state_nxt = SOLICITA;
      end
      SOLICITA: begin
        // An ack on the last allowed cycle still counts as delivered.
        if (bus.disp_ack) begin
          state_nxt  = CARREGA;
          to_cnt_nxt = '0;
        end else begin
          to_cnt_nxt = to_cnt + TO_W'(1);
          if (to_cnt == TO_W'(TIMEOUT - 1)) state_nxt = FALHA;
        end
      end
      CARREGA: state_nxt = IDLE;
      FALHA:   state_nxt = FALHA;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      to_cnt <= '0;
      tray   <= '0;
      stock  <= STOCK_W'(STOCK_BATCHES);
`ifdef CONTADOR_LOTES_EN
      lotes  <= '0;
`endif
    end else begin
      state  <= state_nxt;
      to_cnt <= to_cnt_nxt;

      // The CARREGA update already subtracts a cork taken on that same cycle.
      if (state == CARREGA)                  tray <= tray_sat;
      else if (bus.rolha_usada && tray != '0) tray <= tray - TRAY_W'(1);

      if (bus.abastecer_estoque) stock <= STOCK_W'(STOCK_BATCHES);
      else if (state == CARREGA) stock <= stock - STOCK_W'(1);

`ifdef CONTADOR_LOTES_EN
      if (state == CARREGA && lotes != 8'hFF) lotes <= lotes + 8'd1;
`endif
    end
  end

  assign bus.disp_req      = (state == SOLICITA);
  assign bus.falha         = (state == FALHA);
  assign bus.qt_bandeja    = tray;
  assign bus.qt_estoque    = stock;
  assign bus.bloquear      = (tray == '0);
  assign bus.estoque_vazio = (stock == '0);
`ifdef CONTADOR_LOTES_EN
  assign bus.total_lotes   = lotes;
`endif
endmodule

// File: tb/tb_controle_reabastecimento.sv
// Testbench for controle_reabastecimento. It runs two instances on the same
// stimulus: one with default parameters and one with LOW_THRESH=10, which lets
// tray saturation happen. A reference model predicts the outputs after every
// edge and queues them. A monitor checks them after each rising edge.
module tb_controle_reabastecimento;
  localparam int BATCH = 20, SB = 5, TMAX = 25, TOUT = 15;
  localparam int LOW_A = 5, LOW_B = 10;
  localparam int TW = $clog2(TMAX + 1), SW = $clog2(SB + 1);

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  controle_reabastecimento_if #(.TRAY_W(TW), .STOCK_W(SW)) bus_a ();
  controle_reabastecimento_if #(.TRAY_W(TW), .STOCK_W(SW)) bus_b ();

  controle_reabastecimento dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  controle_reabastecimento #(.LOW_THRESH(LOW_B)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

  typedef struct {
    int tray; int stock; int wcnt; int lotes;
    bit waiting; bit loading; bit faulted;
  } mdl_t;

  typedef struct {
    int id; int tray; int stock; int lotes;
    bit req; bit blq; bit vaz; bit flh;
  } exp_t;

  exp_t q[$];
  mdl_t ma, mb;
  int checks = 0, passes = 0;

  // Reference behaviour: values after one clock edge, from values before it.
  function automatic mdl_t mstep(mdl_t m, int low, bit r, bit used, bit reload, bit ack);
    mdl_t n = m;
    if (r) begin
      n.tray = 0; n.stock = SB; n.wcnt = 0; n.lotes = 0;
      n.waiting = 0; n.loading = 0; n.faulted = 0;
      return n;
    end
    if (m.loading) begin
      n.tray = m.tray + BATCH - int'(used);
      if (n.tray > TMAX) n.tray = TMAX;
      if (m.lotes < 255) n.lotes = m.lotes + 1;
    end else if (used && m.tray > 0) n.tray = m.tray - 1;
    if (reload) n.stock = SB;
    else if (m.loading) n.stock = m.stock - 1;
    n.loading = 0;
    if (!m.faulted && !m.loading) begin
      if (m.waiting) begin
        if (ack) begin
          n.waiting = 0; n.loading = 1; n.wcnt = 0;
        end else begin
          n.wcnt = m.wcnt + 1;
          if (n.wcnt == TOUT) begin n.waiting = 0; n.faulted = 1; end
        end
      end else if (m.tray <= low && m.stock > 0) begin
        n.waiting = 1; n.wcnt = 0;
      end
    end
    return n;
  endfunction

  function automatic exp_t mk(int id, mdl_t m);
    exp_t e;
    e.id = id; e.tray = m.tray; e.stock = m.stock; e.lotes = m.lotes;
    e.req = m.waiting; e.flh = m.faulted;
    e.blq = (m.tray == 0); e.vaz = (m.stock == 0);
    return e;
  endfunction

  task automatic chk(string name, int id, logic [31:0] got, logic [31:0] exp_v);
    checks++;
    if (got !== exp_v)
      $display("FAIL %s dut%0d t=%0t got=%0d expected=%0d", name, id, $time, got, exp_v);
    else passes++;
  endtask

  task automatic step(bit r, bit u, bit rl, bit a);
    @(negedge clk);
    rst = r;
    bus_a.rolha_usada = u; bus_a.abastecer_estoque = rl; bus_a.disp_ack = a;
    bus_b.rolha_usada = u; bus_b.abastecer_estoque = rl; bus_b.disp_ack = a;
    ma = mstep(ma, LOW_A, r, u, rl, a);
    mb = mstep(mb, LOW_B, r, u, rl, a);
    q.push_back(mk(0, ma));
    q.push_back(mk(1, mb));
  endtask

  // Monitor: after each rising edge, consume that edge's predictions.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      while (q.size() > 0) begin
        exp_t e;
        e = q.pop_front();
        if (e.id == 0) begin
          chk("qt_bandeja", 0, 32'(bus_a.qt_bandeja), e.tray);
          chk("qt_estoque", 0, 32'(bus_a.qt_estoque), e.stock);
          chk("disp_req", 0, 32'(bus_a.disp_req), 32'(e.req));
          chk("bloquear", 0, 32'(bus_a.bloquear), 32'(e.blq));
          chk("estoque_vazio", 0, 32'(bus_a.estoque_vazio), 32'(e.vaz));
          chk("falha", 0, 32'(bus_a.falha), 32'(e.flh));
`ifdef CONTADOR_LOTES_EN
          chk("total_lotes", 0, 32'(bus_a.total_lotes), e.lotes);
`endif
        end else begin
          chk("qt_bandeja", 1, 32'(bus_b.qt_bandeja), e.tray);
          chk("qt_estoque", 1, 32'(bus_b.qt_estoque), e.stock);
          chk("disp_req", 1, 32'(bus_b.disp_req), 32'(e.req));
          chk("bloquear", 1, 32'(bus_b.bloquear), 32'(e.blq));
          chk("estoque_vazio", 1, 32'(bus_b.estoque_vazio), 32'(e.vaz));
          chk("falha", 1, 32'(bus_b.falha), 32'(e.flh));
`ifdef CONTADOR_LOTES_EN
          chk("total_lotes", 1, 32'(bus_b.total_lotes), e.lotes);
`endif
        end
      end
    end
  end

  initial begin
    int pu, pa, pr;
    bus_a.rolha_usada = 0; bus_a.abastecer_estoque = 0; bus_a.disp_ack = 0;
    bus_b.rolha_usada = 0; bus_b.abastecer_estoque = 0; bus_b.disp_ack = 0;
    ma = '{default: 0};
    mb = '{default: 0};

    // Reset, then the first refill with the ack held back for 3 cycles.
    step(1, 0, 0, 0); step(1, 0, 0, 0);
    repeat (3) step(0, 0, 0, 0);
    step(0, 0, 0, 1);
    repeat (3) step(0, 0, 0, 0);

    // Drain the tray to the threshold, then ack with a cork taken in CARREGA.
    repeat (15) step(0, 1, 0, 0);
    repeat (2) step(0, 0, 0, 0);
    step(0, 0, 0, 1);
    step(0, 1, 0, 0);
    repeat (2) step(0, 0, 0, 0);

    // Timeout: the tray goes low and the ack never comes. Late acks are ignored.
    repeat (20) step(0, 1, 0, 0);
    repeat (20) step(0, 0, 0, 0);
    repeat (3) step(0, 0, 0, 1);
    repeat (3) step(0, 1, 0, 0);
    step(1, 0, 0, 0);

    // Exhaust the stock with the ack always high, then underflow and reload.
    repeat (150) step(0, 1, 0, 1);
    repeat (3) step(0, 1, 0, 0);
    step(0, 0, 1, 0);
    repeat (4) step(0, 0, 0, 0);
    step(0, 0, 0, 1);
    repeat (3) step(0, 0, 0, 0);
    step(1, 0, 0, 0);

    // Random segments with varied event densities.
    for (int s = 0; s < 25; s++) begin
      pu = $urandom_range(10, 90);
      pa = $urandom_range(0, 60);
      pr = $urandom_range(0, 5);
      if ($urandom_range(0, 1) == 1) step(1, 0, 0, 0);
      for (int c = 0; c < 80; c++)
        step(0, $urandom_range(0, 99) < pu, $urandom_range(0, 99) < pr,
             $urandom_range(0, 99) < pa);
    end

    @(posedge clk);
    #3;
    checks++;
    if (q.size() != 0) $display("FAIL drain queue_left=%0d expected=0", q.size());
    else passes++;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
